// File: rtl/tinyqv_sram_responder.sv
// On-chip byte-addressed RAM that serves TinyQV's streaming instruction fetch and its data port.
// Optional: define TINYQV_SRAM_FAST_CONTINUE_EN to complete burst-continuation accesses with latency 1.
module tinyqv_sram_responder #(
    parameter int ADDR_BITS     = 12,
    parameter int FETCH_LATENCY = 2,
    parameter int DATA_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:1] instr_addr,
    input  logic        instr_fetch_restart,
    input  logic        instr_fetch_stall,
    output logic        instr_fetch_started,
    output logic        instr_fetch_stopped,
    output logic [15:0] instr_data_in,
    output logic        instr_ready,
    input  logic [27:0] data_addr,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    input  logic        data_continue,
    input  logic        data_read_complete,
    input  logic [31:0] data_out,
    output logic        data_ready,
    output logic [31:0] data_in
);
    localparam int         WORDS     = 1 << (ADDR_BITS - 2);
    localparam logic [3:0] FETCH_LAT = 4'(FETCH_LATENCY);
    localparam logic [3:0] DATA_LAT  = 4'(DATA_LATENCY);

    typedef enum logic [2:0] {IDLE, FETCH_WAIT, STREAM, DATA_WAIT, DATA_DONE} state_t;

    state_t               state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic [ADDR_BITS-2:0] fetch_ptr_reg, fetch_ptr_next;
    logic [ADDR_BITS-1:0] daddr_reg, daddr_next;
    logic [1:0]           dsize_reg, dsize_next;
    logic                 dwrite_reg, dwrite_next;
    logic                 started_reg, started_next, stopped_reg, stopped_next;
    logic                 ready_reg, ready_next, data_ready_reg, data_ready_next;
    logic [15:0]          instr_data_reg, instr_data_next;
    logic [31:0]          data_in_reg, data_in_next;

    logic                 data_req, req_write;
    logic [1:0]           req_size;
    logic [3:0]           req_lat;
    logic [ADDR_BITS-1:0] req_addr;
    logic [ADDR_BITS-3:0] ram_idx;
    logic                 ram_we;
    logic [3:0]           ram_be;
    logic [31:0]          ram_wdata, ram_rdata, read_fmt;
    logic [15:0]          fetch_half;

`ifdef TINYQV_SRAM_FAST_CONTINUE_EN
    assign req_lat = data_continue ? 4'd1 : DATA_LAT;
    logic unused_inputs;
    assign unused_inputs = ^{data_read_complete, instr_addr[23:ADDR_BITS], data_addr[26:ADDR_BITS]};
`else
    assign req_lat = DATA_LAT;
    logic unused_inputs;
    assign unused_inputs = ^{data_read_complete, data_continue, instr_addr[23:ADDR_BITS],
                             data_addr[26:ADDR_BITS]};
`endif

    // A write wins over a simultaneous read; bit 27 selects the peripheral space.
    assign req_write = (data_write_n != 2'b11);
    assign data_req  = (req_write || data_read_n != 2'b11) && !data_addr[27];
    assign req_size  = req_write ? data_write_n : data_read_n;

    always_comb begin
        req_addr = data_addr[ADDR_BITS-1:0];
        if (req_size == 2'b01)
            req_addr[0] = 1'b0;
        else if (req_size == 2'b10)
            req_addr[1:0] = 2'b00;
    end

    // One port shared by both streams: the data address owns it only while an access is pending.
    assign ram_idx = (state_reg == DATA_WAIT) ? daddr_reg[ADDR_BITS-1:2]
                                              : fetch_ptr_reg[ADDR_BITS-2:1];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            always_ff @(posedge clk) begin
                if (ram_we && ram_be[gi])
                    mem[ram_idx] <= ram_wdata[8*gi +: 8];
            end
            assign ram_rdata[8*gi +: 8] = mem[ram_idx];
        end
    endgenerate

    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = data_out;
        read_fmt  = ram_rdata;
        case (dsize_reg)
            2'b00: begin
                ram_be    = 4'b0001 << daddr_reg[1:0];
                ram_wdata = {4{data_out[7:0]}};
                read_fmt  = {24'd0, ram_rdata[{daddr_reg[1:0], 3'b000} +: 8]};
            end
            2'b01: begin
                ram_be    = daddr_reg[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{data_out[15:0]}};
                read_fmt  = {16'd0, daddr_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0]};
            end
            default: ;
        endcase
    end

    assign fetch_half = fetch_ptr_reg[0] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        fetch_ptr_next  = fetch_ptr_reg;
        daddr_next      = daddr_reg;
        dsize_next      = dsize_reg;
        dwrite_next     = dwrite_reg;
        started_next    = 1'b0;
        stopped_next    = 1'b0;
        ready_next      = 1'b0;
        data_ready_next = 1'b0;
        instr_data_next = instr_data_reg;
        data_in_next    = data_in_reg;
        ram_we          = 1'b0;
        case (state_reg)
            IDLE, FETCH_WAIT, STREAM: begin
                if (data_req) begin
                    state_next   = DATA_WAIT;
                    daddr_next   = req_addr;
                    dsize_next   = req_size;
                    dwrite_next  = req_write;
                    cnt_next     = req_lat;
                    stopped_next = (state_reg != IDLE);
                end else if (instr_fetch_restart) begin
                    state_next     = FETCH_WAIT;
                    fetch_ptr_next = instr_addr[ADDR_BITS-1:1];
                    cnt_next       = FETCH_LAT;
                    started_next   = 1'b1;
                end else if (state_reg == STREAM || (state_reg == FETCH_WAIT && cnt_reg == 4'd1)) begin
                    state_next      = STREAM;
                    ready_next      = !instr_fetch_stall;
                    instr_data_next = fetch_half;
                    if (!instr_fetch_stall)
                        fetch_ptr_next = fetch_ptr_reg + (ADDR_BITS-1)'(1);
                end else if (state_reg == FETCH_WAIT) begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DATA_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next      = DATA_DONE;
                    data_ready_next = 1'b1;
                    if (dwrite_reg)
                        ram_we = 1'b1;
                    else
                        data_in_next = read_fmt;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DATA_DONE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            fetch_ptr_reg  <= '0;
            daddr_reg      <= '0;
            dsize_reg      <= '0;
            dwrite_reg     <= 1'b0;
            started_reg    <= 1'b0;
            stopped_reg    <= 1'b0;
            ready_reg      <= 1'b0;
            data_ready_reg <= 1'b0;
            instr_data_reg <= '0;
            data_in_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            fetch_ptr_reg  <= fetch_ptr_next;
            daddr_reg      <= daddr_next;
            dsize_reg      <= dsize_next;
            dwrite_reg     <= dwrite_next;
            started_reg    <= started_next;
            stopped_reg    <= stopped_next;
            ready_reg      <= ready_next;
            data_ready_reg <= data_ready_next;
            instr_data_reg <= instr_data_next;
            data_in_reg    <= data_in_next;
        end
    end

    assign instr_fetch_started = started_reg;
    assign instr_fetch_stopped = stopped_reg;
    assign instr_ready         = ready_reg;
    assign instr_data_in       = instr_data_reg;
    assign data_ready          = data_ready_reg;
    assign data_in             = data_in_reg;
endmodule

// File: tb/tb_tinyqv_sram_responder.sv
// Randomized bench for tinyqv_sram_responder against a byte-array memory model and timing rules.
module tb_tinyqv_sram_responder;
    localparam int ADDR_BITS = 12;
    localparam int FL        = 2;
    localparam int DL        = 2;
    localparam int MEM_BYTES = 1 << ADDR_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] instr_addr;
    logic        instr_fetch_restart, instr_fetch_stall;
    logic        instr_fetch_started, instr_fetch_stopped, instr_ready;
    logic [15:0] instr_data_in;
    logic [27:0] data_addr;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_continue, data_read_complete;
    logic [31:0] data_out, data_in;
    logic        data_ready;

    tinyqv_sram_responder #(.ADDR_BITS(ADDR_BITS), .FETCH_LATENCY(FL), .DATA_LATENCY(DL)) dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_fetch_restart(instr_fetch_restart),
        .instr_fetch_stall(instr_fetch_stall), .instr_fetch_started(instr_fetch_started),
        .instr_fetch_stopped(instr_fetch_stopped), .instr_data_in(instr_data_in),
        .instr_ready(instr_ready), .data_addr(data_addr), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_continue(data_continue),
        .data_read_complete(data_read_complete), .data_out(data_out),
        .data_ready(data_ready), .data_in(data_in)
    );

    always #5 clk = ~clk;

    logic [7:0] model_mem [MEM_BYTES];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         streaming = 1'b0;
    int         fetch_ptr = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int bytes_of(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [27:0] addr, input logic [1:0] size);
        logic [31:0] v;
        int n, base;
        v    = '0;
        n    = bytes_of(size);
        base = int'(addr[ADDR_BITS-1:0]) & ~(n - 1);
        for (int k = 0; k < n; k++) v[8*k +: 8] = model_mem[(base + k) % MEM_BYTES];
        return v;
    endfunction

    task automatic model_write(input logic [27:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n, base;
        n    = bytes_of(size);
        base = int'(addr[ADDR_BITS-1:0]) & ~(n - 1);
        for (int k = 0; k < n; k++) model_mem[(base + k) % MEM_BYTES] = wdata[8*k +: 8];
    endtask

    function automatic logic [15:0] model_half(input int ptr);
        return {model_mem[(ptr + 1) % MEM_BYTES], model_mem[ptr % MEM_BYTES]};
    endfunction

    task automatic drive_idle();
        instr_fetch_restart = 1'b0;
        instr_fetch_stall   = 1'b0;
        data_write_n        = 2'b11;
        data_read_n         = 2'b11;
        data_continue       = 1'b0;
    endtask

    // One data access from request to the cycle after data_ready; returns at a negedge with the DUT idle.
    task automatic data_access(input bit wr, input logic [1:0] size, input logic [27:0] addr,
                               input logic [31:0] wdata, input bit cont, input bit with_restart);
        int          lat, got_at;
        logic [31:0] exp_rd;
        lat = DL;
`ifdef TINYQV_SRAM_FAST_CONTINUE_EN
        if (cont) lat = 1;
`endif
        exp_rd              = model_read(addr, size);
        data_addr           = addr;
        data_write_n        = wr ? size : 2'b11;
        data_read_n         = (wr && $urandom_range(0, 1) == 0) ? 2'b11 :
                              (wr ? 2'($urandom_range(0, 2)) : size);
        data_continue       = cont;
        data_out            = wdata;
        instr_fetch_restart = with_restart;
        instr_fetch_stall   = 1'b0;
        got_at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) check_value("stopped_pulse", 32'(instr_fetch_stopped), 32'(streaming));
            check_value("fetch_quiet", {29'd0, instr_ready, instr_fetch_started,
                        (i > 1) && instr_fetch_stopped}, 32'd0);
            if (data_ready) begin
                got_at = i;
                break;
            end
        end
        check_value("data_latency", 32'(got_at), 32'(lat + 1));
        if (wr) model_write(addr, size, wdata);
        else    check_value("read_data", data_in, exp_rd);
        drive_idle();
        @(negedge clk);
        check_value("ready_one_cycle", 32'(data_ready), 32'd0);
        streaming = 1'b0;
    endtask

    // Restart at start and collect count halfwords; stall_mode 0=none, 1=random, 2=hold 3 cycles from 4th.
    task automatic fetch_run(input logic [23:0] start, input int count, input int stall_mode);
        int got, stall_left;
        bit stall_prev, s;
        fetch_ptr           = int'(start[ADDR_BITS-1:0]);
        instr_addr          = start[23:1];
        instr_fetch_restart = 1'b1;
        instr_fetch_stall   = 1'b0;
        stall_prev = 1'b0;
        got        = 0;
        stall_left = 0;
        for (int i = 1; i <= 200 && got < count; i++) begin
            @(negedge clk);
            instr_fetch_restart = 1'b0;
            check_value("fetch_started", 32'(instr_fetch_started), 32'(i == 1));
            check_value("fetch_ready", 32'(instr_ready), 32'((i > FL) && !stall_prev));
            if (instr_ready) begin
                check_value("fetch_data", 32'(instr_data_in), 32'(model_half(fetch_ptr)));
                fetch_ptr = (fetch_ptr + 2) % MEM_BYTES;
                got++;
            end
            if (stall_mode == 2 && got == 4 && instr_ready) stall_left = 3;
            case (stall_mode)
                1:       s = ($urandom_range(0, 3) == 0);
                2:       s = (stall_left > 0);
                default: s = 1'b0;
            endcase
            if (stall_left > 0) stall_left--;
            stall_prev        = s;
            instr_fetch_stall = s;
        end
        check_value("fetch_count", 32'(got), 32'(count));
        instr_fetch_stall = 1'b0;
        streaming = 1'b1;
    endtask

    // Peripheral-space read while streaming: must be invisible to the responder.
    task automatic periph_read(input int cycles);
        data_addr   = {1'b1, 27'($urandom)};
        data_read_n = 2'b10;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_value("periph_no_ready", {30'd0, data_ready, instr_fetch_stopped}, 32'd0);
            check_value("periph_fetch_on", 32'(instr_ready), 32'd1);
            check_value("periph_fetch_data", 32'(instr_data_in), 32'(model_half(fetch_ptr)));
            fetch_ptr = (fetch_ptr + 2) % MEM_BYTES;
        end
        data_read_n = 2'b11;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value(tag, {28'd0, instr_fetch_started, instr_fetch_stopped, instr_ready, data_ready}, 32'd0);
        check_value({tag, "_instr_data"}, 32'(instr_data_in), 32'd0);
        check_value({tag, "_data_in"}, data_in, 32'd0);
    endtask

    initial begin
        logic [27:0] ad;
        int          op;
        rst                = 1'b1;
        instr_addr         = '0;
        data_addr          = '0;
        data_out           = '0;
        data_read_complete = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < MEM_BYTES / 4; a++) begin
            ad       = {1'b0, 27'($urandom)};
            ad[11:0] = {10'(a), 2'b00};
            data_access(1'b1, 2'b10, ad, $urandom, 1'b0, 1'b0);
        end

        data_access(1'b1, 2'b01, 28'h040, 32'h1111, 1'b0, 1'b0);
        data_access(1'b1, 2'b01, 28'h042, 32'h2222, 1'b0, 1'b0);
        data_access(1'b1, 2'b01, 28'h044, 32'h3333, 1'b0, 1'b0);
        data_access(1'b1, 2'b01, 28'h046, 32'h4444, 1'b0, 1'b0);
        data_access(1'b1, 2'b10, 28'h200, 32'hDEADBEEF, 1'b0, 1'b0);
        data_access(1'b1, 2'b10, 28'h300, 32'h0, 1'b0, 1'b0);

        fetch_run(24'h000040, 6, 2);

        data_access(1'b0, 2'b10, 28'h200, 32'h0, 1'b0, 1'b0);
        check_value("preempt_read", data_in, 32'hDEADBEEF);
        repeat (4) begin
            @(negedge clk);
            check_value("no_resume", {30'd0, instr_ready, instr_fetch_started}, 32'd0);
        end

        data_access(1'b1, 2'b00, 28'h301, 32'h000000A5, 1'b0, 1'b0);
        data_access(1'b0, 2'b10, 28'h300, 32'h0, 1'b0, 1'b0);
        check_value("byte_write_word", data_in, 32'h0000A500);
        data_access(1'b1, 2'b01, 28'h303, 32'h00001234, 1'b0, 1'b0);
        data_access(1'b0, 2'b10, 28'h300, 32'h0, 1'b0, 1'b0);
        check_value("half_write_word", data_in, 32'h1234A500);

        fetch_run(24'h000080, 3, 0);
        periph_read(5);
        data_access(1'b0, 2'b01, 28'h082, 32'h0, 1'b0, 1'b0);
        data_access(1'b0, 2'b10, 28'h044, 32'h0, 1'b0, 1'b1);

        data_access(1'b1, 2'b10, 28'h500, 32'hCAFE0001, 1'b0, 1'b0);
        data_access(1'b1, 2'b10, 28'h504, 32'hCAFE0002, 1'b1, 1'b0);
        data_access(1'b0, 2'b10, 28'h500, 32'h0, 1'b0, 1'b0);
        data_access(1'b0, 2'b10, 28'h504, 32'h0, 1'b1, 1'b0);

        fetch_run(24'h000180, 4, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid_stream");
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        streaming = 1'b0;
        @(negedge clk);
        fetch_run(24'h000100, 6, 0);

        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 2);
            ad = {1'b0, 27'($urandom)};
            if (op == 2)
                fetch_run({12'($urandom), 11'($urandom), 1'b0}, $urandom_range(1, 8), 1);
            else
                data_access(op == 0, 2'($urandom_range(0, 2)), ad, $urandom,
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tinyqv_sram_responder.md
# tinyqv_sram_responder

Memory-side responder for the TinyQV CPU's instruction-fetch and data ports, backed by an on-chip byte-addressed RAM. Serves the CPU's streaming 16-bit instruction fetch and its 8/16/32-bit data reads and writes through one single-ported array. Data accesses take priority and preempt the fetch stream. Used for FPGA builds and simulation in place of the QSPI memory controller.

## Interface
Parameters:
- ADDR_BITS, 12: RAM size is 2^ADDR_BITS bytes. Addresses wrap modulo the RAM size.
- FETCH_LATENCY, 2: cycles from fetch start to the first `instr_ready`. Legal range is 1..15.
- DATA_LATENCY, 2: cycles from request accept to `data_ready`. Legal range is 1..15.

Ports. Signal names match the CPU ports they connect to.
- clk, input, 1: the single clock.
- rst, input, 1: reset, asynchronous and active-high.
- instr_addr, input, 23 (`[23:1]`): fetch start halfword address.
- instr_fetch_restart, input, 1: request to start or restart fetching at `instr_addr`.
- instr_fetch_stall, input, 1: CPU buffer is full after this cycle.
- instr_fetch_started, output, 1: one-cycle pulse; fetch stream has begun.
- instr_fetch_stopped, output, 1: one-cycle pulse; fetch stream was aborted.
- instr_data_in, output, 16: fetched halfword. Valid only while `instr_ready` is high.
- instr_ready, output, 1: `instr_data_in` is valid this cycle.
- data_addr, input, 28: data byte address. Only accesses with `data_addr[27]`=0 are serviced.
- data_write_n, input, 2: write request. 11=none, 00=byte, 01=half, 10=word.
- data_read_n, input, 2: read request, same encoding as `data_write_n`.
- data_continue, input, 1: this access continues a multi-register burst.
- data_read_complete, input, 1: CPU has consumed the read data. Informational only; ignored.
- data_out, input, 32: write data, least-significant lanes first.
- data_ready, output, 1: one-cycle pulse; the access is complete.
- data_in, output, 32: read data, zero-extended.

## Operation
- FSM has five states: IDLE, FETCH_WAIT, STREAM, DATA_WAIT, DATA_DONE.
- A data request is a read request (`data_read_n`≠11) or a write request (`data_write_n`≠11), in either case with `data_addr[27]`=0.
  - Requests with `data_addr[27]`=1 are ignored entirely; they belong to the peripherals.
- IDLE:
  - Data request → DATA_WAIT.
  - Otherwise, `instr_fetch_restart` high → latch `instr_addr`, load the latency counter, go to FETCH_WAIT.
- FETCH_WAIT:
  - Pulse `instr_fetch_started` on the first cycle of the state.
  - Count down FETCH_LATENCY, then go to STREAM.
- STREAM:
  - Each cycle, `instr_ready` (registered) = !`instr_fetch_stall`.
  - `instr_data_in` = RAM halfword at the fetch pointer.
  - Each cycle `instr_ready` is asserted, the pointer advances by 2 bytes.
- `instr_fetch_restart` high in FETCH_WAIT or STREAM, with no data request:
  - Relatch `instr_addr` and re-enter FETCH_WAIT.
  - `instr_fetch_started` pulses again.
- Data request in FETCH_WAIT or STREAM:
  - Next cycle: `instr_fetch_stopped` pulses and `instr_ready` drops.
  - Go to DATA_WAIT.
  - Data beats a restart that arrives in the same cycle.
- DATA_WAIT:
  - Latch the address and size; count down the latency.
  - Reads: the RAM read occurs on the final count; `data_in` is updated in the cycle `data_ready` pulses.
  - Writes: bytes from the low lanes of `data_out` are committed on the final count.
  - Size alignment: address bits below the access size are ignored (forced aligned).
- DATA_DONE: lasts one cycle. Request inputs are ignored there, because the CPU deasserts them the cycle after `data_ready`. Then → IDLE.
- The CPU reasserts `instr_fetch_restart` after a stop; the responder resumes from IDLE.
- The RAM array is not reset. All other state is cleared by `rst` at any time, including mid-access. A write interrupted by reset before its final count is discarded.

## Timing
- Reset values:
  - `instr_fetch_started`, `instr_fetch_stopped`, `instr_ready`, `data_ready`: 0.
  - `instr_data_in`, `data_in`: 0.
  - FSM: IDLE.
- All outputs are registered.
- Fetch:
  - `instr_fetch_restart` sampled high in IDLE at edge N → `instr_fetch_started` is high in cycle N+1.
  - First `instr_ready` is in cycle N+1+FETCH_LATENCY, so it is always at least one cycle after started.
- Stall: `instr_fetch_stall` high at edge M → `instr_ready`=0 in cycle M+1. At most one further halfword is delivered after the stall is seen.
- Data: request accepted at edge N → `data_ready` is high in cycle N+DATA_LATENCY+1, for exactly one cycle.
- Simultaneous read and write requests: the write is serviced and the read is ignored.

## Configuration
- `TINYQV_SRAM_FAST_CONTINUE_EN` defined: an accepted request with `data_continue`=1 uses a latency of 1 instead of DATA_LATENCY.
- Undefined: every access uses DATA_LATENCY; `data_continue` is ignored.

## Test plan
- Reset mid-stream: assert `rst` during STREAM → all outputs are 0 immediately. After release, a restart at 0x000100 → started pulse, then halfwords from 0x100, 0x102, …
- Fetch with stall: RAM[0x40..0x47] = 0x1111, 0x2222, 0x3333, 0x4444; restart at 0x40 with FETCH_LATENCY=2 → started at N+1; `instr_ready` at N+3..N+6 carrying those four values. Hold stall high from the 4th ready → no 5th ready until stall drops. Then the 5th halfword is 0x48.
- Data preempts fetch: word read of 0x200 (contents 0xDEADBEEF) issued during STREAM → `instr_fetch_stopped` the next cycle; `data_ready` with `data_in`=0xDEADBEEF at accept+3. Fetch resumes only after restart.
- Byte and half writes:
  - Byte write of 0xA5 at 0x301 → word at 0x300 reads 0x0000A500 (prior contents zero).
  - Half write of 0x1234 at 0x303 → aligned to 0x302; word at 0x300 reads 0x1234A500.
- Peripheral ignore and priority: a read with `data_addr[27]`=1 → no `data_ready`, fetch continues. Simultaneous restart and data request in IDLE → data is serviced first.
- `TINYQV_SRAM_FAST_CONTINUE_EN`: two-word burst (second request has `data_continue`=1) → second `data_ready` arrives 2 cycles after its accept when defined, DATA_LATENCY+1 cycles when undefined.
